// File: rtl/ln_stat_accum.sv
// LayerNorm statistics stage: drains one N-sample vector from the input FIFO and
// produces its sum, sum of squares, floored mean and clamped variance.
module ln_stat_accum #(
   parameter  int WIDTH = 9,
   parameter  int N     = 8,
   localparam int LOG2N = $clog2(N)
) (
   input  logic                            i_clk,
   input  logic                            i_rstn,
   input  logic                            i_start,
   input  logic                            i_empty,
   input  logic signed [WIDTH-1:0]         i_data,
   output logic                            o_rd_en,
   output logic                            o_busy,
   output logic                            o_done,
   output logic signed [WIDTH+LOG2N-1:0]   o_sum,
   output logic        [2*WIDTH-2+LOG2N:0] o_sumsq,
   output logic signed [WIDTH-1:0]         o_mean,
   output logic        [2*WIDTH-2:0]       o_var
);

   localparam int SUMW = WIDTH + LOG2N;
   localparam int SQW  = 2*WIDTH - 1;
   localparam int SSQW = SQW + LOG2N;

   typedef enum logic [1:0] {IDLE, ACCUM, CALC, DONE} state_t;

   state_t                   state_q, state_d;
   logic signed [SUMW-1:0]   sumAcc_q, sumAcc_d;
   logic        [SSQW-1:0]   sqAcc_q, sqAcc_d;
   logic        [LOG2N-1:0]  count_q, count_d;
   logic signed [SUMW-1:0]   sumOut_q, sumOut_d;
   logic        [SSQW-1:0]   sqOut_q, sqOut_d;
   logic signed [WIDTH-1:0]  meanOut_q, meanOut_d;
   logic        [SQW-1:0]    varOut_q, varOut_d;
   logic                     done_q, done_d;

   logic                     rdEn;
   logic signed [SQW-1:0]    dataExt;
   logic signed [SQW-1:0]    dataSq;
   logic signed [WIDTH-1:0]  meanCalc;
   logic signed [SQW-1:0]    meanExt;
   logic        [SQW-1:0]    m2;
   logic        [SQW-1:0]    ex2;
   logic        [SQW-1:0]    varCalc;

   assign rdEn = (state_q == ACCUM) && !i_empty;

   // A square of a WIDTH-bit signed value always fits in 2*WIDTH-1 bits as a non-negative number.
   assign dataExt = {{(SQW-WIDTH){i_data[WIDTH-1]}}, i_data};
   assign dataSq  = dataExt * dataExt;

   // Dropping the low LOG2N bits of the signed sum is the arithmetic shift, so the mean floors.
   assign meanCalc = sumAcc_q[SUMW-1:LOG2N];
   assign meanExt  = {{(SQW-WIDTH){meanCalc[WIDTH-1]}}, meanCalc};
   assign m2       = meanExt * meanExt;
   assign ex2      = sqAcc_q[SSQW-1:LOG2N];
   assign varCalc  = (ex2 >= m2) ? (ex2 - m2) : '0;

   always_comb begin
      state_d   = state_q;
      sumAcc_d  = sumAcc_q;
      sqAcc_d   = sqAcc_q;
      count_d   = count_q;
      sumOut_d  = sumOut_q;
      sqOut_d   = sqOut_q;
      meanOut_d = meanOut_q;
      varOut_d  = varOut_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_start) begin
               state_d  = ACCUM;
               sumAcc_d = '0;
               sqAcc_d  = '0;
               count_d  = '0;
            end
         end
         ACCUM: begin
            if (rdEn) begin
               sumAcc_d = sumAcc_q + {{LOG2N{i_data[WIDTH-1]}}, i_data};
               sqAcc_d  = sqAcc_q + {{LOG2N{1'b0}}, dataSq};
               count_d  = count_q + LOG2N'(1);
               if (count_q == LOG2N'(N-1)) begin
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            sumOut_d  = sumAcc_q;
            sqOut_d   = sqAcc_q;
            meanOut_d = meanCalc;
            varOut_d  = varCalc;
            done_d    = 1'b1;
            state_d   = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q   <= IDLE;
         sumAcc_q  <= '0;
         sqAcc_q   <= '0;
         count_q   <= '0;
         sumOut_q  <= '0;
         sqOut_q   <= '0;
         meanOut_q <= '0;
         varOut_q  <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         sumAcc_q  <= sumAcc_d;
         sqAcc_q   <= sqAcc_d;
         count_q   <= count_d;
         sumOut_q  <= sumOut_d;
         sqOut_q   <= sqOut_d;
         meanOut_q <= meanOut_d;
         varOut_q  <= varOut_d;
         done_q    <= done_d;
      end
   end

   assign o_rd_en = rdEn;
   assign o_busy  = (state_q != IDLE);
   assign o_done  = done_q;
   assign o_sum   = sumOut_q;
   assign o_sumsq = sqOut_q;
   assign o_mean  = meanOut_q;
   assign o_var   = varOut_q;

endmodule

// File: tb/tb_ln_stat_accum.sv
// Bench for ln_stat_accum: FIFO-driven vectors compared against a plain-arithmetic
// statistics model (floor mean, clamped variance).
module tb_ln_stat_accum;

   localparam int WIDTH = 9;
   localparam int N     = 8;
   localparam int LOG2N = 3;

   logic                            i_clk;
   logic                            i_rstn;
   logic                            i_start;
   logic                            i_empty;
   logic signed [WIDTH-1:0]         i_data;
   logic                            o_rd_en;
   logic                            o_busy;
   logic                            o_done;
   logic signed [WIDTH+LOG2N-1:0]   o_sum;
   logic        [2*WIDTH-2+LOG2N:0] o_sumsq;
   logic signed [WIDTH-1:0]         o_mean;
   logic        [2*WIDTH-2:0]       o_var;

   ln_stat_accum #(.WIDTH(WIDTH), .N(N)) dut (
      .i_clk   (i_clk),
      .i_rstn  (i_rstn),
      .i_start (i_start),
      .i_empty (i_empty),
      .i_data  (i_data),
      .o_rd_en (o_rd_en),
      .o_busy  (o_busy),
      .o_done  (o_done),
      .o_sum   (o_sum),
      .o_sumsq (o_sumsq),
      .o_mean  (o_mean),
      .o_var   (o_var)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int total = 0;
   int bad   = 0;

   logic signed [WIDTH-1:0] vec [N];
   integer expSum, expSumsq, expMean, expVar;
   integer obsSum, obsSumsq, obsMean, obsVar;
   integer idleSum;
   int     rdHigh, stallRdBad, accCycles;
   bit     timedOut;
   logic   calcRdEn, calcDone, calcBusy, doneSeen, idleDone, idleBusy;

   // Reference statistics straight from the definitions: floor(sum/N), floor(sumsq/N), clamp at 0.
   function automatic void model();
      integer s = 0;
      integer q = 0;
      integer v, ex2, m2;
      for (int i = 0; i < N; i++) begin
         v = vec[i];
         s = s + v;
         q = q + v * v;
      end
      expSum   = s;
      expSumsq = q;
      if (s >= 0) expMean = s / N;
      else        expMean = -((-s + N - 1) / N);
      ex2 = q / N;
      m2  = expMean * expMean;
      expVar = (ex2 >= m2) ? ex2 - m2 : 0;
   endfunction

   // Runs one vector through the FIFO handshake, optionally stalling, and records what the DUT did.
   task automatic applyStimulus(input int stallAfter, input int stallLen, input bit startInStall);
      int idx = 0;
      int stallDone = 0;
      rdHigh = 0; stallRdBad = 0; accCycles = 0; timedOut = 0;
      @(negedge i_clk);
      i_start = 1'b1; i_empty = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
      while (idx < N && accCycles < 200) begin
         if (idx == stallAfter && stallDone < stallLen) begin
            i_empty = 1'b1; i_data = WIDTH'($urandom); i_start = startInStall;
            stallDone++;
         end else begin
            i_empty = 1'b0; i_data = vec[idx]; i_start = 1'b0;
         end
         #1;
         if (o_rd_en) begin
            rdHigh++;
            if (i_empty) stallRdBad++;
            idx++;
         end
         accCycles++;
         @(negedge i_clk);
      end
      i_start = 1'b0;
      if (idx < N) timedOut = 1'b1;
      i_empty = 1'b0; i_data = WIDTH'($urandom);
      #1;
      calcRdEn = o_rd_en; calcDone = o_done; calcBusy = o_busy;
      @(negedge i_clk);
      #1;
      doneSeen = o_done;
      obsSum = o_sum; obsSumsq = o_sumsq; obsMean = o_mean; obsVar = o_var;
      @(negedge i_clk);
      #1;
      idleDone = o_done; idleBusy = o_busy; idleSum = o_sum;
      i_empty = 1'b1;
   endtask

   task automatic test_reset();
      i_rstn = 1'b0; i_start = 1'b0; i_empty = 1'b1; i_data = '0;
      #2;
      total++; if ({o_rd_en, o_busy, o_done} !== 3'b000) begin bad++; $display("[TB] FAIL reset_ctrl: got %b want 000", {o_rd_en, o_busy, o_done}); end
      total++; if (o_sum !== '0 || o_sumsq !== '0) begin bad++; $display("[TB] FAIL reset_sums: got %0d/%0d want 0/0", o_sum, o_sumsq); end
      total++; if (o_mean !== '0 || o_var !== '0) begin bad++; $display("[TB] FAIL reset_stats: got %0d/%0d want 0/0", o_mean, o_var); end
      @(negedge i_clk);
      i_rstn = 1'b1; i_empty = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge i_clk);
         #1;
         total++; if (o_rd_en !== 1'b0 || o_busy !== 1'b0) begin bad++; $display("[TB] FAIL idle_no_read cycle %0d: rd_en=%b busy=%b want 0 0", c, o_rd_en, o_busy); end
      end
      i_empty = 1'b1;
   endtask

   task automatic test_ramp();
      for (int i = 0; i < N; i++) vec[i] = WIDTH'(i + 1);
      model();
      applyStimulus(99, 0, 1'b0);
      total++; if (timedOut) begin bad++; $display("[TB] FAIL ramp_timeout: consumed %0d want %0d", rdHigh, N); end
      total++; if (rdHigh !== 8) begin bad++; $display("[TB] FAIL ramp_rd_cycles: got %0d want 8", rdHigh); end
      total++; if (calcRdEn !== 1'b0 || calcDone !== 1'b0) begin bad++; $display("[TB] FAIL ramp_calc_cycle: rd_en=%b done=%b want 0 0", calcRdEn, calcDone); end
      total++; if (doneSeen !== 1'b1) begin bad++; $display("[TB] FAIL ramp_done_latency: got %b want 1", doneSeen); end
      total++; if (idleDone !== 1'b0) begin bad++; $display("[TB] FAIL ramp_done_pulse: got %b want 0", idleDone); end
      total++; if (obsSum !== 36 || expSum !== 36) begin bad++; $display("[TB] FAIL ramp_sum: got %0d want 36", obsSum); end
      total++; if (obsSumsq !== 204) begin bad++; $display("[TB] FAIL ramp_sumsq: got %0d want 204", obsSumsq); end
      total++; if (obsMean !== 4) begin bad++; $display("[TB] FAIL ramp_mean: got %0d want 4", obsMean); end
      total++; if (obsVar !== 9) begin bad++; $display("[TB] FAIL ramp_var: got %0d want 9", obsVar); end
      total++; if (idleSum !== expSum) begin bad++; $display("[TB] FAIL ramp_hold: got %0d want %0d", idleSum, expSum); end
   endtask

   task automatic test_negative();
      for (int i = 0; i < N; i++) vec[i] = -9'sd256;
      model();
      applyStimulus(99, 0, 1'b0);
      total++; if (obsSum !== -2048) begin bad++; $display("[TB] FAIL neg_sum: got %0d want -2048", obsSum); end
      total++; if (obsSumsq !== 524288) begin bad++; $display("[TB] FAIL neg_sumsq: got %0d want 524288", obsSumsq); end
      total++; if (obsMean !== -256) begin bad++; $display("[TB] FAIL neg_mean: got %0d want -256", obsMean); end
      total++; if (obsVar !== expVar) begin bad++; $display("[TB] FAIL neg_var: got %0d want %0d", obsVar, expVar); end
      for (int i = 0; i < N; i++) vec[i] = (i % 2 == 0) ? -9'sd3 : 9'sd3;
      model();
      applyStimulus(99, 0, 1'b0);
      total++; if (obsSum !== 0) begin bad++; $display("[TB] FAIL alt_sum: got %0d want 0", obsSum); end
      total++; if (obsSumsq !== 72) begin bad++; $display("[TB] FAIL alt_sumsq: got %0d want 72", obsSumsq); end
      total++; if (obsMean !== 0) begin bad++; $display("[TB] FAIL alt_mean: got %0d want 0", obsMean); end
      total++; if (obsVar !== 9) begin bad++; $display("[TB] FAIL alt_var: got %0d want 9", obsVar); end
   endtask

   task automatic test_floor_clamp();
      for (int i = 0; i < N; i++) vec[i] = '0;
      vec[0] = -9'sd1;
      model();
      applyStimulus(99, 0, 1'b0);
      total++; if (obsSum !== -1) begin bad++; $display("[TB] FAIL floor_sum: got %0d want -1", obsSum); end
      total++; if (obsSumsq !== 1) begin bad++; $display("[TB] FAIL floor_sumsq: got %0d want 1", obsSumsq); end
      total++; if (obsMean !== -1) begin bad++; $display("[TB] FAIL floor_mean: got %0d want -1", obsMean); end
      total++; if (obsVar !== 0) begin bad++; $display("[TB] FAIL clamp_var: got %0d want 0", obsVar); end
   endtask

   task automatic test_stall();
      for (int i = 0; i < N; i++) vec[i] = WIDTH'(i + 1);
      model();
      applyStimulus(3, 3, 1'b1);
      total++; if (stallRdBad !== 0) begin bad++; $display("[TB] FAIL stall_rd_en: got %0d reads while empty want 0", stallRdBad); end
      total++; if (accCycles !== 11) begin bad++; $display("[TB] FAIL stall_accum_cycles: got %0d want 11", accCycles); end
      total++; if (rdHigh !== 8) begin bad++; $display("[TB] FAIL stall_rd_cycles: got %0d want 8", rdHigh); end
      total++; if (calcBusy !== 1'b1 || doneSeen !== 1'b1) begin bad++; $display("[TB] FAIL stall_flow: busy=%b done=%b want 1 1", calcBusy, doneSeen); end
      total++; if (obsSum !== expSum || obsSumsq !== expSumsq) begin bad++; $display("[TB] FAIL stall_sums: got %0d/%0d want %0d/%0d", obsSum, obsSumsq, expSum, expSumsq); end
      total++; if (obsMean !== expMean || obsVar !== expVar) begin bad++; $display("[TB] FAIL stall_stats: got %0d/%0d want %0d/%0d", obsMean, obsVar, expMean, expVar); end
      total++; if (idleBusy !== 1'b0) begin bad++; $display("[TB] FAIL stall_start_ignored: busy=%b want 0", idleBusy); end
   endtask

   task automatic test_random();
      for (int it = 0; it < 12; it++) begin
         for (int i = 0; i < N; i++) vec[i] = WIDTH'($urandom);
         model();
         applyStimulus(int'($urandom_range(0, N-1)), int'($urandom_range(0, 4)), 1'b0);
         total++; if (timedOut || stallRdBad !== 0) begin bad++; $display("[TB] FAIL rand%0d_handshake: reads=%0d bad_reads=%0d", it, rdHigh, stallRdBad); end
         total++; if (obsSum !== expSum) begin bad++; $display("[TB] FAIL rand%0d_sum: got %0d want %0d", it, obsSum, expSum); end
         total++; if (obsSumsq !== expSumsq) begin bad++; $display("[TB] FAIL rand%0d_sumsq: got %0d want %0d", it, obsSumsq, expSumsq); end
         total++; if (obsMean !== expMean) begin bad++; $display("[TB] FAIL rand%0d_mean: got %0d want %0d", it, obsMean, expMean); end
         total++; if (obsVar !== expVar) begin bad++; $display("[TB] FAIL rand%0d_var: got %0d want %0d", it, obsVar, expVar); end
      end
   endtask

   task automatic test_reset_mid();
      @(negedge i_clk);
      i_start = 1'b1; i_empty = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
      for (int k = 0; k < 5; k++) begin
         i_empty = 1'b0; i_data = 9'sd7;
         @(negedge i_clk);
      end
      i_empty = 1'b1;
      i_rstn = 1'b0;
      #1;
      total++; if (o_busy !== 1'b0 || o_rd_en !== 1'b0 || o_done !== 1'b0) begin bad++; $display("[TB] FAIL midreset_ctrl: busy=%b rd_en=%b done=%b want 0", o_busy, o_rd_en, o_done); end
      total++; if (o_sum !== '0 || o_sumsq !== '0 || o_mean !== '0 || o_var !== '0) begin bad++; $display("[TB] FAIL midreset_outputs: %0d %0d %0d %0d want 0", o_sum, o_sumsq, o_mean, o_var); end
      @(negedge i_clk);
      i_rstn = 1'b1;
      for (int i = 0; i < N; i++) vec[i] = 9'sd5;
      model();
      applyStimulus(99, 0, 1'b0);
      total++; if (obsSum !== 40 || obsSumsq !== 200) begin bad++; $display("[TB] FAIL midreset_sums: got %0d/%0d want 40/200", obsSum, obsSumsq); end
      total++; if (obsMean !== 5 || obsVar !== 0) begin bad++; $display("[TB] FAIL midreset_stats: got %0d/%0d want 5/0", obsMean, obsVar); end
   endtask

   task automatic test_back_to_back();
      logic signed [WIDTH-1:0] vecA [N];
      logic signed [WIDTH-1:0] vecB [N];
      integer eSum [2];
      integer eVar [2];
      integer oSum [2];
      integer oVar [2];
      int doneCyc [2];
      int consumed = 0;
      int cyc = 0;
      int nDone = 0;
      for (int i = 0; i < N; i++) begin
         vecA[i] = WIDTH'($urandom);
         vecB[i] = WIDTH'($urandom);
      end
      vec = vecA; model(); eSum[0] = expSum; eVar[0] = expVar;
      vec = vecB; model(); eSum[1] = expSum; eVar[1] = expVar;
      @(negedge i_clk);
      i_start = 1'b1;
      while (nDone < 2 && cyc < 100) begin
         if (consumed < 2*N) begin
            i_empty = 1'b0;
            i_data  = (consumed < N) ? vecA[consumed] : vecB[consumed - N];
         end else begin
            i_empty = 1'b1;
         end
         #1;
         if (o_rd_en) consumed++;
         if (o_done) begin
            doneCyc[nDone] = cyc;
            oSum[nDone] = o_sum;
            oVar[nDone] = o_var;
            nDone++;
            if (nDone == 2) i_start = 1'b0;
         end
         cyc++;
         @(negedge i_clk);
      end
      i_start = 1'b0; i_empty = 1'b1;
      total++; if (nDone !== 2) begin bad++; $display("[TB] FAIL b2b_done_count: got %0d want 2", nDone); end
      if (nDone == 2) begin
         total++; if (doneCyc[1] - doneCyc[0] !== 11) begin bad++; $display("[TB] FAIL b2b_period: got %0d want 11", doneCyc[1] - doneCyc[0]); end
         for (int v = 0; v < 2; v++) begin
            total++; if (oSum[v] !== eSum[v]) begin bad++; $display("[TB] FAIL b2b_sum%0d: got %0d want %0d", v, oSum[v], eSum[v]); end
            total++; if (oVar[v] !== eVar[v]) begin bad++; $display("[TB] FAIL b2b_var%0d: got %0d want %0d", v, oVar[v], eVar[v]); end
         end
      end
      @(negedge i_clk);
      #1;
      total++; if (o_busy !== 1'b0) begin bad++; $display("[TB] FAIL b2b_stop: busy=%b want 0", o_busy); end
   endtask

   initial begin
      $display("[TB] starting ln_stat_accum bench");
      test_reset();
      test_ramp();
      test_negative();
      test_floor_clamp();
      test_stall();
      test_random();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ln_stat_accum.md
Name: ln_stat_accum

Overview:
- Downstream consumer of the LayerNorm input FIFO.
- Drains one vector of N signed samples from the FIFO and accumulates the sum and the sum of squares.
- Produces the vector mean and variance for the normalize stage, with a one-cycle done pulse.
- N is a power of two, so all division is arithmetic shifting; the block contains no divider.

Parameters:
- WIDTH, 9: sample width, two's-complement signed.
- N, 8: samples per vector. Must be a power of two and at least 2.
- LOG2N, $clog2(N): derived localparam. Not to be overridden.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rstn  in  1  reset, asynchronous, active-low.
- i_start  in  1  begin a new vector; sampled only in IDLE.
- i_empty  in  1  FIFO empty flag.
- i_data  in  WIDTH  FIFO read data, signed; valid in the same cycle as o_rd_en.
- o_rd_en  out  1  FIFO read enable.
- o_busy  out  1  high in any state other than IDLE.
- o_done  out  1  one-cycle pulse; results valid.
- o_sum  out  WIDTH+LOG2N  signed sum of the vector.
- o_sumsq  out  2*WIDTH-1+LOG2N  unsigned sum of squares.
- o_mean  out  WIDTH  signed mean.
- o_var  out  2*WIDTH-1  unsigned variance.

Behaviour:
- Reset: FSM goes to IDLE. All accumulators, the sample counter and all outputs are 0 (o_rd_en=0, o_done=0, o_busy=0). Reset asserted mid-vector aborts it; partial sums are discarded.
- FSM states: IDLE, ACCUM, CALC, DONE.
- IDLE:
  - i_start=1 moves to ACCUM and clears sum, sumsq and count.
  - Result outputs hold their previous values.
- ACCUM, read handshake:
  - o_rd_en = !i_empty, combinational, in this state only.
  - A sample is consumed in every cycle where o_rd_en=1.
  - i_data is taken in that same cycle, because the FIFO read data is combinational.
- ACCUM, per consumed sample:
  - sum += sign-extended i_data.
  - sumsq += i_data*i_data, a signed multiply giving a non-negative product of 2*WIDTH-1 bits.
  - count += 1.
- ACCUM, stall and exit:
  - i_empty=1 is a stall: no consumption and no state change, for any length of time.
  - On the edge that consumes sample N (count == N-1 and o_rd_en=1), go to CALC.
  - o_rd_en is 0 from that point on, so no sample is ever taken beyond N.
- CALC, single cycle. The outputs below are registered on the CALC->DONE edge:
  - o_sum = sum; o_sumsq = sumsq.
  - o_mean = sum >>> LOG2N. This is an arithmetic shift, so it floors toward minus infinity (e.g. sum -1 gives mean -1).
  - ex2 = sumsq >> LOG2N.
  - m2 = o_mean*o_mean, unsigned, 2*WIDTH-1 bits.
  - o_var = (ex2 >= m2) ? ex2 - m2 : 0. A negative variance caused by flooring is clamped to 0.
- DONE: o_done=1 for exactly this cycle, then go to IDLE.
- Latency: o_done is high in the second cycle after the edge that captures sample N.
- Result outputs hold until the next CALC->DONE edge.
- i_start in ACCUM, CALC or DONE is ignored; it is not queued.
- i_start held high is re-sampled in IDLE and starts a back-to-back vector. The minimum period is N+3 cycles when the FIFO never stalls.
- No overflow is possible: the widths above cover N samples of -2^(WIDTH-1).

Test Plan:
- Reset values: assert i_rstn=0 -> all outputs 0, o_busy=0. Release reset, i_empty=0, i_start=0 for 5 cycles -> o_rd_en stays 0.
- Ramp vector: i_start, then FIFO supplies 1..8 with no stall -> o_rd_en high exactly 8 cycles. Results o_sum=36, o_sumsq=204, o_mean=4, o_var=25-16=9. o_done is a single pulse 2 cycles after the 8th capture edge.
- Most-negative input: eight samples of -256 -> o_sum=-2048, o_sumsq=524288, o_mean=-256, o_var=0 (no overflow). Alternating -3,3 -> o_sum=0, o_sumsq=72, o_mean=0, o_var=9.
- Floor and clamp: samples -1,0,0,0,0,0,0,0 -> o_sum=-1, o_mean=-1, o_sumsq=1, ex2=0. o_var=0 from the clamp, not a wrapped value.
- Empty stall: i_empty=1 for 3 cycles after sample 3 -> o_rd_en=0 and the accumulators frozen during the stall. Final results equal the unstalled run. i_start pulsed mid-vector is ignored.
- Reset mid-operation: assert i_rstn=0 after sample 5 -> immediate IDLE with outputs 0. A new vector of all 5s then gives o_sum=40, o_sumsq=200, o_mean=5, o_var=0 (no leftover partial sum). i_start held high gives two back-to-back vectors, 11 cycles between the two o_done pulses.
